// File: rtl/matrix_pkg.sv
// Shared matrix definitions for the column streamer and the transpose unit:
// default dimensions, the streamer FSM state type, and the bit-position
// helpers for the MSB-first row/column packing used on every matrix bus.
package matrix_pkg;

  localparam int DIM_DEF = 5;
  localparam int EW_DEF  = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // MSB of row r in a packed DIM x DIM matrix.
  function automatic int row_msb(input int r, input int dim, input int ew);
    return dim * dim * ew - 1 - r * dim * ew;
  endfunction

  // MSB of element (r, c) in a packed DIM x DIM matrix.
  function automatic int elem_msb(input int r, input int c, input int dim, input int ew);
    return row_msb(r, dim, ew) - c * ew;
  endfunction

  // MSB of row element r in a packed column vector.
  function automatic int col_elem_msb(input int r, input int dim, input int ew);
    return dim * ew - 1 - r * ew;
  endfunction

endpackage

// File: rtl/col_extract.sv
// Combinational column selector: picks column i_idx out of a packed matrix
// and repacks it MSB-first (row 0 in the top element). Pure bit moves only.
module col_extract
  import matrix_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int EW  = EW_DEF
) (
  input  logic [DIM*DIM*EW-1:0]    i_matrix,
  input  logic [$clog2(DIM)-1:0]   i_idx,
  output logic [DIM*EW-1:0]        o_col
);

  localparam int IW = $clog2(DIM);

  // Mux each row's element of the selected column into its column slot.
  always_comb begin
    o_col = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (i_idx == IW'(c)) begin
          o_col[col_elem_msb(r, DIM, EW) -: EW] = i_matrix[elem_msb(r, c, DIM, EW) -: EW];
        end
      end
    end
  end

endmodule

// File: rtl/col_streamer.sv
// Column streamer: accepts a whole DIM x DIM matrix in one handshake, then
// emits it column by column (column 0 first) on a valid/ready output.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// producer holds data stable while valid is high and ready is low.
// After the last column one idle cycle (load_ready=1) separates matrices.
// Optional: define COL_STREAMER_LAST_EN to add col_last, high with the
// final column of each matrix.
module col_streamer
  import matrix_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int EW  = EW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIM*DIM*EW-1:0]     m_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic signed [DIM*EW-1:0]  col,
  output logic                      col_valid,
  input  logic                      col_ready,
  output logic [$clog2(DIM)-1:0]    col_idx,
  output logic                      busy
`ifdef COL_STREAMER_LAST_EN
  ,
  output logic                      col_last
`endif
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [DIM*DIM*EW-1:0] r_matrix;
  logic [IW-1:0]         r_col_idx;
  logic                  w_load_hs;
  logic                  w_col_hs;
  logic                  w_last;
  logic [DIM*EW-1:0]     w_col;

  assign w_last = (r_col_idx == LAST_IDX);

  // Next-state, handshake decode and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_load_hs    = 1'b0;
    w_col_hs     = 1'b0;
    load_ready   = 1'b0;
    col_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_load_hs    = 1'b1;
          w_next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        col_valid = 1'b1;
        busy      = 1'b1;
        if (col_ready) begin
          w_col_hs = 1'b1;
          if (w_last) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Matrix holding register; only written by a load handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_matrix <= '0;
    end else if (w_load_hs) begin
      r_matrix <= m_in;
    end
  end

  // Column index: restarts on load, advances per column handshake, wraps after the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_idx <= '0;
    end else if (w_load_hs) begin
      r_col_idx <= '0;
    end else if (w_col_hs) begin
      r_col_idx <= w_last ? '0 : r_col_idx + IW'(1);
    end
  end

  col_extract #(
    .DIM (DIM),
    .EW  (EW)
  ) u_col_extract (
    .i_matrix (r_matrix),
    .i_idx    (r_col_idx),
    .o_col    (w_col)
  );

  // The column bus reads zero whenever no matrix is being streamed.
  assign col     = (r_state == ST_STREAM) ? $signed(w_col) : '0;
  assign col_idx = r_col_idx;

`ifdef COL_STREAMER_LAST_EN
  assign col_last = (r_state == ST_STREAM) && w_last;
`endif

endmodule

// File: tb/tb_col_streamer.sv
// Bench for col_streamer: directed matrices with hand-computed columns, plus
// a cycle model (held matrix as signed integers, current column number) that
// is compared against every output on every falling edge after reset.
module tb_col_streamer;

  localparam int DIM = 5;
  localparam int EW  = 8;
  localparam int MW  = DIM * DIM * EW;
  localparam int CW  = DIM * EW;
  localparam int IW  = $clog2(DIM);

  // ---------------- clock / reset / DUT ----------------
  logic                 clk;
  logic                 rst;
  logic [MW-1:0]        m_in;
  logic                 load_valid;
  logic                 load_ready;
  logic signed [CW-1:0] col;
  logic                 col_valid;
  logic                 col_ready;
  logic [IW-1:0]        col_idx;
  logic                 busy;
`ifdef COL_STREAMER_LAST_EN
  logic                 col_last;
`endif
  wire  [CW-1:0]        col_u = col;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  col_streamer #(
    .DIM (DIM),
    .EW  (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_in       (m_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .col        (col),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_idx    (col_idx),
    .busy       (busy)
`ifdef COL_STREAMER_LAST_EN
    ,
    .col_last   (col_last)
`endif
  );

  // ---------------- check helper ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_on   = 1'b0;
  bit m_held = 1'b0;
  int m_idx  = 0;
  int m_mat[DIM][DIM];

  // Protocol-level model: a matrix is either held or not; if held, one column
  // number is current and moves on when the downstream takes it.
  always @(posedge clk) begin
    if (rst) begin
      m_on   <= 1'b1;
      m_held <= 1'b0;
      m_idx  <= 0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          m_mat[r][c] <= 0;
    end else if (!m_held && load_valid) begin
      m_held <= 1'b1;
      m_idx  <= 0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          m_mat[r][c] <= int'($signed(m_in[MW-1-r*CW-c*EW -: EW]));
    end else if (m_held && col_ready) begin
      if (m_idx == DIM - 1) begin
        m_held <= 1'b0;
        m_idx  <= 0;
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  function automatic logic [CW-1:0] model_col();
    logic [CW-1:0] e;
    int v;
    e = '0;
    if (m_held) begin
      for (int r = 0; r < DIM; r++) begin
        v = m_mat[r][m_idx];
        e[CW-1-r*EW -: EW] = v[EW-1:0];
      end
    end
    return e;
  endfunction

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("m_load_ready", 64'(load_ready), 64'(!m_held));
      chk("m_col_valid",  64'(col_valid),  64'(m_held));
      chk("m_busy",       64'(busy),       64'(m_held));
      chk("m_col_idx",    64'(col_idx),    64'(m_idx));
      chk("m_col",        64'(col_u),      64'(model_col()));
`ifdef COL_STREAMER_LAST_EN
      chk("m_col_last",   64'(col_last),   64'(m_held && (m_idx == DIM - 1)));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [MW-1:0] to_packed(input int a[DIM][DIM]);
    logic [MW-1:0] p;
    int v;
    p = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        v = a[r][c];
        p[MW-1-r*CW-c*EW -: EW] = v[EW-1:0];
      end
    return p;
  endfunction

  // Called at a falling edge; returns one falling edge later with column 0 showing.
  task automatic load_matrix(input logic [MW-1:0] m);
    m_in       = m;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (load_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, 64'(load_ready), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  int mat_a[DIM][DIM];
  int mat_b[DIM][DIM];
  int mat_c[DIM][DIM];
  int mat_r[DIM][DIM];
  logic [CW-1:0] exp_a[DIM];
  logic [CW-1:0] exp_b[DIM];

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    m_in       = '0;
    col_ready  = 1'b0;

    for (int r = 0; r < DIM; r++) begin
      mat_a[r] = '{1, 3, 2, -5 + 10, 0};
      mat_b[r] = '{0, 0, 0, 0, 0};
      for (int c = 0; c < DIM; c++) mat_c[r][c] = 10 * r + c + 1;
    end
    mat_b[0] = '{-1, -3, -2, -5, 0};
    exp_a = '{40'h0101010101, 40'h0303030303, 40'h0202020202, 40'h0505050505, 40'h0000000000};
    exp_b = '{40'hFF00000000, 40'hFD00000000, 40'hFE00000000, 40'hFB00000000, 40'h0000000000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_load_ready", 64'(load_ready), 64'(1));
    chk("rst_col_valid",  64'(col_valid),  64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_col",        64'(col_u),      64'(0));
    chk("rst_col_idx",    64'(col_idx),    64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Matrix A, no back-pressure: five consecutive columns then one bubble
    col_ready = 1'b1;
    load_matrix(to_packed(mat_a));
    for (int k = 0; k < DIM; k++) begin
      chk($sformatf("a_col%0d", k), 64'(col_u), 64'(exp_a[k]));
      chk($sformatf("a_idx%0d", k), 64'(col_idx), 64'(k));
      chk($sformatf("a_lr%0d", k), 64'(load_ready), 64'(0));
      @(negedge clk);
    end
    chk("a_bubble_lr", 64'(load_ready), 64'(1));
    chk("a_bubble_cv", 64'(col_valid),  64'(0));
    chk("a_bubble_col", 64'(col_u),     64'(0));

    // Matrix B: negative bytes must come through unchanged
    load_matrix(to_packed(mat_b));
    for (int k = 0; k < DIM; k++) begin
      chk($sformatf("b_col%0d", k), 64'(col_u), 64'(exp_b[k]));
      @(negedge clk);
    end
    chk("b_bubble_cv", 64'(col_valid), 64'(0));

    // Back-pressure at column 2 for three cycles
    load_matrix(to_packed(mat_a));
    @(negedge clk);
    @(negedge clk);
    col_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_col%0d", k), 64'(col_u),   64'(exp_a[2]));
      chk($sformatf("bp_hold_idx%0d", k), 64'(col_idx), 64'(2));
    end
    col_ready = 1'b1;
    @(negedge clk);
    chk("bp_col3", 64'(col_u), 64'(exp_a[3]));
    @(negedge clk);
    chk("bp_col4", 64'(col_u), 64'(exp_a[4]));
    @(negedge clk);
    chk("bp_done_cv", 64'(col_valid), 64'(0));

    // Load request during streaming is ignored until the bubble
    load_matrix(to_packed(mat_a));
    m_in       = to_packed(mat_c);
    load_valid = 1'b1;
    for (int k = 0; k < DIM; k++) begin
      chk($sformatf("ig_col%0d", k), 64'(col_u), 64'(exp_a[k]));
      chk($sformatf("ig_lr%0d", k), 64'(load_ready), 64'(0));
      @(negedge clk);
    end
    chk("ig_bubble_lr", 64'(load_ready), 64'(1));
    @(negedge clk);
    load_valid = 1'b0;
    chk("ig_c_col0", 64'(col_u),   64'(40'h010B151F29));
    chk("ig_c_idx0", 64'(col_idx), 64'(0));
    wait_idle("ig");

    // Reset in the middle of a stream
    load_matrix(to_packed(mat_b));
    repeat (3) @(negedge clk);
    chk("mr_idx3", 64'(col_idx), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_cv",  64'(col_valid),  64'(0));
    chk("mr_col", 64'(col_u),      64'(0));
    chk("mr_lr",  64'(load_ready), 64'(1));
    chk("mr_idx", 64'(col_idx),    64'(0));
    @(negedge clk);
    chk("mr_no_more_cv", 64'(col_valid), 64'(0));
    load_matrix(to_packed(mat_a));
    chk("mr_reload_idx", 64'(col_idx), 64'(0));
    chk("mr_reload_col", 64'(col_u),   64'(exp_a[0]));
    wait_idle("mr");

    // Arbitrary signed matrices under irregular back-pressure (model-checked)
    for (int n = 0; n < 3; n++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mat_r[r][c] = int'($urandom_range(0, 255)) - 128;
      load_matrix(to_packed(mat_r));
      begin
        int cyc;
        cyc = 0;
        while (load_ready !== 1'b1 && cyc < 100) begin
          col_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          cyc++;
        end
        chk($sformatf("rnd%0d_timeout", n), 64'(load_ready), 64'(1));
      end
      col_ready = 1'b1;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
